// File: rtl/ext_unit_pipe.sv
// Pipelined immediate / load-lane extension unit for the MIPS datapath.
// One registered output stage plus a skid register; valid/ready on both sides.
module ext_unit_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned OFF_W = $clog2(OUT_W / 8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] a,
  input  logic [2:0]       mode,
  input  logic [OFF_W-1:0] off,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             err
);

  localparam int unsigned SelW = $clog2(2 * OUT_W);

  localparam logic [2:0] ModeZero  = 3'd0;
  localparam logic [2:0] ModeSign  = 3'd1;
  localparam logic [2:0] ModeUpper = 3'd2;
  localparam logic [2:0] ModeByteZ = 3'd3;
  localparam logic [2:0] ModeByteS = 3'd4;
  localparam logic [2:0] ModeHalfZ = 3'd5;
  localparam logic [2:0] ModeHalfS = 3'd6;

  logic [2*OUT_W-1:0] a_pad;
  logic [SelW-1:0]    byte_base;
  logic [SelW-1:0]    half_base;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [OUT_W-1:0]   calc_y;
  logic               calc_err;

  // Zero padding above a keeps lane selects in range for any legal OUT_W.
  always_comb begin
    a_pad        = {{OUT_W{1'b0}}, a};
    byte_base    = SelW'({off, 3'b000});
    half_base    = byte_base;
    half_base[3] = 1'b0;
    byte_v       = a_pad[byte_base +: 8];
    half_v       = a_pad[half_base +: 16];
    calc_y       = '0;
    calc_err     = 1'b0;
    case (mode)
      ModeZero:  calc_y = {{(OUT_W - IN_W){1'b0}}, a[IN_W-1:0]};
      ModeSign:  calc_y = {{(OUT_W - IN_W){a[IN_W-1]}}, a[IN_W-1:0]};
      ModeUpper: calc_y = {a[IN_W-1:0], {(OUT_W - IN_W){1'b0}}};
      ModeByteZ: calc_y = {{(OUT_W - 8){1'b0}}, byte_v};
      ModeByteS: calc_y = {{(OUT_W - 8){byte_v[7]}}, byte_v};
      ModeHalfZ, ModeHalfS: begin
        if (off[0]) begin
          calc_err = 1'b1;
        end else if (mode == ModeHalfS) begin
          calc_y = {{(OUT_W - 16){half_v[15]}}, half_v};
        end else begin
          calc_y = {{(OUT_W - 16){1'b0}}, half_v};
        end
      end
      default:   calc_err = 1'b1;
    endcase
  end

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_y_q, skid_y_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;

  logic accept;
  logic out_load;

  assign accept   = in_valid && in_ready_q;
  assign out_load = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    y_d          = y_q;
    err_d        = err_q;
    skid_valid_d = skid_valid_q;
    skid_y_d     = skid_y_q;
    skid_err_d   = skid_err_q;
    if (out_load) begin
      // Skid full implies in_ready was low, so no accept can collide here.
      if (skid_valid_q) begin
        y_d          = skid_y_q;
        err_d        = skid_err_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        y_d         = calc_y;
        err_d       = calc_err;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_y_d     = calc_y;
      skid_err_d   = calc_err;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      y_q          <= '0;
      err_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_y_q     <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      y_q          <= y_d;
      err_q        <= err_d;
      skid_valid_q <= skid_valid_d;
      skid_y_q     <= skid_y_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed self-checking bench for ext_unit_pipe (default 16 -> 32 configuration).
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [2:0]  mode;
  logic [1:0]  off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ext_unit_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .mode      (mode),
    .off       (off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; a = 32'hDEAD_BEEF; mode = 3'd0; off = 2'd0; out_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (y !== 32'h0) begin n_fail++; $display("FAIL rst_y: got %h want 0", y); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    reset = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_immediates();
    logic [31:0] exp_y [3] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000};
    out_ready = 1'b1; a = 32'h0000_8001; off = 2'd0;
    for (int i = 0; i < 3; i++) begin
      mode = 3'(i); in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== exp_y[i] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL imm[%0d]: got v=%b y=%h e=%b want v=1 y=%h e=0", i, out_valid, y, err,
                 exp_y[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL imm_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_loads();
    logic [2:0]  md [5]    = '{3'd4, 3'd3, 3'd6, 3'd5, 3'd4};
    logic [1:0]  of [5]    = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp_y [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h0000_007F};
    out_ready = 1'b1; a = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      mode = md[i]; off = of[i]; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== exp_y[i] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL load[%0d]: got v=%b y=%h e=%b want v=1 y=%h e=0", i, out_valid, y, err,
                 exp_y[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    logic [2:0]  md [4]    = '{3'd6, 3'd5, 3'd7, 3'd0};
    logic [1:0]  of [4]    = '{2'd1, 2'd3, 2'd0, 2'd0};
    logic [31:0] exp_y [4] = '{32'h0, 32'h0, 32'h0, 32'h0000_FFFF};
    logic        exp_e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1; a = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      mode = md[i]; off = of[i]; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== exp_y[i] || err !== exp_e[i]) begin
        n_fail++;
        $display("FAIL errcase[%0d]: got v=%b y=%h e=%b want v=1 y=%h e=%b", i, out_valid, y,
                 err, exp_y[i], exp_e[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic        iv [9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] av [9]  = '{1, 2, 3, 3, 3, 3, 4, 5, 0};
    logic        ordy [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] ey [9]  = '{1, 1, 1, 1, 2, 3, 4, 5, 0};
    logic        eov [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic        eir [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    mode = 3'd0; off = 2'd0;
    for (int i = 0; i < 9; i++) begin
      in_valid = iv[i]; a = av[i]; out_ready = ordy[i];
      tick();
      n_checks++;
      if (out_valid !== eov[i] || in_ready !== eir[i] || (eov[i] && y !== ey[i])) begin
        n_fail++;
        $display("FAIL bp[%0d]: got v=%b rdy=%b y=%h want v=%b rdy=%b y=%h", i, out_valid,
                 in_ready, y, eov[i], eir[i], ey[i]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    mode = 3'd0; off = 2'd0; out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h11;
    tick();
    a = 32'h22;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || y !== 32'h11) begin
      n_fail++;
      $display("FAIL mid_fill: got rdy=%b y=%h want rdy=0 y=00000011", in_ready, y);
    end
    in_valid = 1'b0; reset = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got v=%b rdy=%b y=%h e=%b want 0 0 0 0", out_valid, in_ready, y,
               err);
    end
    reset = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rel: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    in_valid = 1'b1; a = 32'h33;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || y !== 32'h33) begin
      n_fail++;
      $display("FAIL mid_fresh: got v=%b y=%h want v=1 y=00000033", out_valid, y);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_noreplay: got v=%b y=%h want v=0", out_valid, y);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; a = '0; mode = '0; off = '0; out_ready = 1'b0;
    test_reset();
    test_immediates();
    test_loads();
    test_errors();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
